// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator between the EX/MEM stage and a big-endian word-read DRAM.
package lsu_mem_ctrl_pkg;

    typedef enum logic [2:0] {
        LSU_LB  = 3'd0,
        LSU_LH  = 3'd1,
        LSU_LW  = 3'd2,
        LSU_LBU = 3'd3,
        LSU_LHU = 3'd4,
        LSU_SB  = 3'd5,
        LSU_SH  = 3'd6,
        LSU_SW  = 3'd7
    } load_store_func_code;

    localparam logic [1:0] LSU_ERR_OK      = 2'b00;
    localparam logic [1:0] LSU_ERR_ALIGN   = 2'b01;
    localparam logic [1:0] LSU_ERR_RANGE   = 2'b10;
    localparam logic [1:0] LSU_ERR_TIMEOUT = 2'b11;

endpackage

module lsu_mem_ctrl
    import lsu_mem_ctrl_pkg::*;
#(
    parameter int unsigned MEM_BYTES      = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                lsu_valid_ip,
    input  load_store_func_code lsu_operator_ip,
    input  logic [31:0]         lsu_addr_ip,
    input  logic [31:0]         lsu_wdata_ip,
    output logic                lsu_ready_op,
    output logic                lsu_busy_op,
    output logic                lsu_done_op,
    output logic [31:0]         lsu_rdata_op,
    output logic [1:0]          lsu_err_op,
    output logic                data_req_op,
    output logic [31:0]         data_addr_op,
    output logic                data_we_op,
    output logic [3:0]          data_be_op,
    output logic [31:0]         wdata_op,
    output load_store_func_code lsu_operator_op,
    input  logic                mem_gnt_ip,
    input  logic [31:0]         load_data_ip
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    load_store_func_code op_q, op_d;
    logic [1:0]          off_q, off_d;

    logic                ready_d, busy_d, done_d, req_d, we_d;
    logic [31:0]         rdata_d, addr_d, wdata_d;
    logic [1:0]          err_d;
    logic [3:0]          be_d;
    load_store_func_code opo_d;

    function automatic logic is_store(input load_store_func_code op);
        return (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW);
    endfunction

    // Halfwords need an even address, words a multiple of four.
    function automatic logic misaligned(input load_store_func_code op, input logic [1:0] off);
        logic bad;
        case (op)
            LSU_LH, LSU_LHU, LSU_SH: bad = off[0];
            LSU_LW, LSU_SW:          bad = (off != 2'b00);
            default:                 bad = 1'b0;
        endcase
        return bad;
    endfunction

    // be[3] is the lowest byte address within the word (big-endian lanes).
    function automatic logic [3:0] store_be(input load_store_func_code op, input logic [1:0] off);
        logic [3:0] be;
        case (op)
            LSU_SB:  be = 4'b1000 >> off;
            LSU_SH:  be = off[1] ? 4'b0011 : 4'b1100;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_wdata(input load_store_func_code op, input logic [1:0] off,
                                                input logic [31:0] d);
        logic [31:0] w;
        case (op)
            LSU_SB:  w = {4{d[7:0]}};
            LSU_SH:  w = off[1] ? {16'h0000, d[15:0]} : {d[15:0], 16'h0000};
            default: w = d;
        endcase
        return w;
    endfunction

    // Pick the addressed byte/half out of the DRAM word and extend it.
    function automatic logic [31:0] format_load(input load_store_func_code op, input logic [1:0] off,
                                                input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        h = off[1] ? w[15:0] : w[31:16];
        case (op)
            LSU_LB:  r = {{24{b[7]}}, b};
            LSU_LBU: r = {24'h000000, b};
            LSU_LH:  r = {{16{h[15]}}, h};
            LSU_LHU: r = {16'h0000, h};
            LSU_LW:  r = w;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    // Next-state and next registered-output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        off_d   = off_q;
        ready_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        rdata_d = 32'h0000_0000;
        err_d   = LSU_ERR_OK;
        req_d   = 1'b0;
        addr_d  = 32'h0000_0000;
        we_d    = 1'b0;
        be_d    = 4'b0000;
        wdata_d = 32'h0000_0000;
        opo_d   = LSU_LB;

        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                cnt_d   = '0;
                if (lsu_valid_ip && lsu_ready_op) begin
                    op_d    = lsu_operator_ip;
                    off_d   = lsu_addr_ip[1:0];
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    if (misaligned(lsu_operator_ip, lsu_addr_ip[1:0])) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        err_d   = LSU_ERR_ALIGN;
                    end else if (lsu_addr_ip >= 32'(MEM_BYTES)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        err_d   = LSU_ERR_RANGE;
                    end else begin
                        state_d = ST_REQ;
                        req_d   = 1'b1;
                        addr_d  = {lsu_addr_ip[31:2], 2'b00};
                        we_d    = is_store(lsu_operator_ip);
                        be_d    = store_be(lsu_operator_ip, lsu_addr_ip[1:0]);
                        wdata_d = store_wdata(lsu_operator_ip, lsu_addr_ip[1:0], lsu_wdata_ip);
                        opo_d   = is_store(lsu_operator_ip) ? lsu_operator_ip : LSU_LW;
                    end
                end
            end
            ST_REQ: begin
                busy_d = 1'b1;
                if (mem_gnt_ip) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    rdata_d = is_store(op_q) ? 32'h0000_0000 : format_load(op_q, off_q, load_data_ip);
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    err_d   = LSU_ERR_TIMEOUT;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    req_d   = 1'b1;
                    addr_d  = data_addr_op;
                    we_d    = data_we_op;
                    be_d    = data_be_op;
                    wdata_d = wdata_op;
                    opo_d   = lsu_operator_op;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // State, captured access and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            op_q            <= LSU_LB;
            off_q           <= 2'b00;
            lsu_ready_op    <= 1'b1;
            lsu_busy_op     <= 1'b0;
            lsu_done_op     <= 1'b0;
            lsu_rdata_op    <= 32'h0000_0000;
            lsu_err_op      <= LSU_ERR_OK;
            data_req_op     <= 1'b0;
            data_addr_op    <= 32'h0000_0000;
            data_we_op      <= 1'b0;
            data_be_op      <= 4'b0000;
            wdata_op        <= 32'h0000_0000;
            lsu_operator_op <= LSU_LB;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            op_q            <= op_d;
            off_q           <= off_d;
            lsu_ready_op    <= ready_d;
            lsu_busy_op     <= busy_d;
            lsu_done_op     <= done_d;
            lsu_rdata_op    <= rdata_d;
            lsu_err_op      <= err_d;
            data_req_op     <= req_d;
            data_addr_op    <= addr_d;
            data_we_op      <= we_d;
            data_be_op      <= be_d;
            wdata_op        <= wdata_d;
            lsu_operator_op <= opo_d;
        end
    end

endmodule
